// File: rtl/regfile_port_arbiter.sv
// Shares the register file port set between the CPU datapath and a debug port,
// clearing r1..rN after reset and guaranteeing debug progress via a starvation guard.
module regfile_port_arbiter #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned REGBITS        = 4,
  parameter int unsigned STARVE_LIM     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [REGBITS-1:0] cpu_ra1,
  input  logic [REGBITS-1:0] cpu_ra2,
  input  logic [WIDTH-1:0]   cpu_wd,
  output logic               cpu_stall,
  output logic [WIDTH-1:0]   cpu_rd1,
  output logic [WIDTH-1:0]   cpu_rd2,
  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [REGBITS-1:0] dbg_addr,
  input  logic [WIDTH-1:0]   dbg_wd,
  output logic               dbg_ack,
  output logic [WIDTH-1:0]   dbg_rdata,
  output logic               init_done,
  output logic               rf_regwrite,
  output logic [REGBITS-1:0] rf_ra1,
  output logic [REGBITS-1:0] rf_ra2,
  output logic [WIDTH-1:0]   rf_wd,
  input  logic [WIDTH-1:0]   rf_rd1,
  input  logic [WIDTH-1:0]   rf_rd2
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0]      LIM       = SW'(STARVE_LIM);
  localparam logic [REGBITS-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic   RST_DONE  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

  state_t             state, state_nxt;
  logic [REGBITS-1:0] clr_cnt;
  logic [SW-1:0]      starve_cnt;
  logic               dbg_ok, dbg_gnt, cpu_gnt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nxt;
  end

  // Next state: leave the clear sweep once the top register has been written
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
  end

  // Arbitration and register-file port steering
  always_comb begin
    dbg_ok      = dbg_req & ~dbg_ack;
    dbg_gnt     = 1'b0;
    cpu_gnt     = 1'b0;
    rf_regwrite = 1'b0;
    rf_ra1      = '0;
    rf_ra2      = '0;
    rf_wd       = '0;
    case (state)
      ST_INIT: begin
        rf_regwrite = 1'b1;
        rf_ra2      = clr_cnt;
      end
      ST_RUN: begin
        dbg_gnt = dbg_ok & (~cpu_req | (starve_cnt == LIM));
        cpu_gnt = cpu_req & ~dbg_gnt;
        if (dbg_gnt) begin
          rf_ra2      = dbg_addr;
          rf_wd       = dbg_wd;
          rf_regwrite = dbg_we;
        end else if (cpu_gnt) begin
          rf_ra1      = cpu_ra1;
          rf_ra2      = cpu_ra2;
          rf_wd       = cpu_wd;
          rf_regwrite = cpu_we;
        end
      end
      default: ;
    endcase
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  assign cpu_rd1 = rf_rd1;
  assign cpu_rd2 = rf_rd2;

  // Sweep counter, starvation guard and debug response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt    <= REGBITS'(1);
      starve_cnt <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      init_done  <= RST_DONE;
    end else begin
      dbg_ack <= dbg_gnt;
      if (dbg_gnt) dbg_rdata <= rf_rd2;
      if (state == ST_INIT) clr_cnt <= clr_cnt + REGBITS'(1);
      if (state == ST_INIT && state_nxt == ST_RUN) init_done <= 1'b1;
      if (dbg_ok & cpu_gnt)
        starve_cnt <= (starve_cnt == LIM) ? LIM : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: a transaction-level register model predicts
// every grant and read value; a negedge monitor checks whatever the DUT presents.
module tb_regfile_port_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned RB  = 4;
  localparam int unsigned LIM = 4;
  localparam int unsigned NR  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, cpu_stall;
  logic [RB-1:0] cpu_ra1, cpu_ra2;
  logic [W-1:0]  cpu_wd, cpu_rd1, cpu_rd2;
  logic          dbg_req, dbg_we, dbg_ack, init_done;
  logic [RB-1:0] dbg_addr;
  logic [W-1:0]  dbg_wd, dbg_rdata;
  logic          rf_regwrite;
  logic [RB-1:0] rf_ra1, rf_ra2;
  logic [W-1:0]  rf_wd, rf_rd1, rf_rd2;

  regfile_port_arbiter #(.WIDTH(W), .REGBITS(RB), .STARVE_LIM(LIM), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ra1(cpu_ra1), .cpu_ra2(cpu_ra2), .cpu_wd(cpu_wd),
    .cpu_stall(cpu_stall), .cpu_rd1(cpu_rd1), .cpu_rd2(cpu_rd2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done),
    .rf_regwrite(rf_regwrite), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  initial forever #5 clk = ~clk;

  // Register file attached to the arbiter; pre loads garbage so the sweep is observable
  logic         pre;
  logic [W-1:0] rf_mem [NR];
  assign rf_rd1 = (rf_ra1 == '0) ? '0 : rf_mem[rf_ra1];
  assign rf_rd2 = (rf_ra2 == '0) ? '0 : rf_mem[rf_ra2];
  always_ff @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < int'(NR); i++) rf_mem[i] <= W'(32'h5A00 + i);
    end else if (rf_regwrite) begin
      rf_mem[rf_ra2] <= rf_wd;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [2*W-1:0] cpu_q [$];
  logic [W-1:0]   dbg_q [$];
  logic           stall_q [$];

  // Reference model: register contents plus how long debug has been kept waiting
  logic [W-1:0] m_regs [NR];
  int           m_wait;
  bit           m_ack;

  logic          c_req, c_we, d_req, d_we;
  logic [RB-1:0] c_ra1, c_ra2, d_addr;
  logic [W-1:0]  c_wd, d_wd;
  bit            c_pend, d_pend, cg, dg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mrd(input logic [RB-1:0] a);
    return (a == '0) ? '0 : m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_wait = 0;
    m_ack  = 1'b0;
  endtask

  // Apply staged inputs for one cycle and record what the model expects from it
  task automatic step(output bit cgo, output bit dgo);
    bit ok;
    @(posedge clk);
    #1;
    cpu_req = c_req; cpu_we = c_we; cpu_ra1 = c_ra1; cpu_ra2 = c_ra2; cpu_wd = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wd = d_wd;
    ok  = d_req && !m_ack;
    dgo = ok && (!c_req || m_wait >= int'(LIM));
    cgo = c_req && !dgo;
    stall_q.push_back(c_req && !cgo);
    if (cgo) begin
      cpu_q.push_back({mrd(c_ra1), mrd(c_ra2)});
      if (c_we) m_regs[c_ra2] = c_wd;
    end
    if (dgo) begin
      dbg_q.push_back(mrd(d_addr));
      if (d_we) m_regs[d_addr] = d_wd;
    end
    m_wait = (ok && cgo) ? m_wait + 1 : 0;
    m_ack  = dgo;
  endtask

  task automatic new_cpu();
    c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
    c_ra1 = RB'($urandom); c_ra2 = RB'($urandom); c_wd = W'($urandom);
  endtask

  task automatic new_dbg();
    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
    d_addr = RB'($urandom); d_wd = W'($urandom);
  endtask

  // Called right after reset release with cpu_req high
  task automatic sweep_check();
    for (int i = 1; i < int'(NR); i++) begin
      @(negedge clk);
      chk("sweep", 64'({rf_regwrite, rf_ra1, rf_ra2, rf_wd, cpu_stall, init_done, dbg_ack}),
          64'({1'b1, RB'(0), RB'(i), W'(0), 1'b1, 1'b0, 1'b0}));
      @(posedge clk);
    end
    #1;
    cpu_req = 1'b0; dbg_req = 1'b0; c_req = 1'b0; d_req = 1'b0; c_pend = 1'b0; d_pend = 1'b0;
    @(negedge clk);
    chk("init_done", 64'({init_done, rf_regwrite, cpu_stall}), 64'({1'b1, 1'b0, 1'b0}));
    model_clear();
  endtask

  task automatic rand_phase(input int n, input int cpct, input int dpct);
    for (int i = 0; i < n; i++) begin
      if (!c_pend) begin
        if (int'($urandom_range(0, 99)) < cpct) begin new_cpu(); c_pend = 1'b1; end
        else c_req = 1'b0;
      end
      if (!d_pend) begin
        if (int'($urandom_range(0, 99)) < dpct) begin new_dbg(); d_pend = 1'b1; end
        else d_req = 1'b0;
      end
      step(cg, dg);
      if (cg) c_pend = 1'b0;
      if (dg) d_pend = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 5; k++) begin
      c_req = 1'b0; c_pend = 1'b0;
      if (!d_pend) d_req = 1'b0;
      step(cg, dg);
      if (dg) d_pend = 1'b0;
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  logic           mon_s;
  logic [2*W-1:0] mon_c;
  logic [W-1:0]   mon_d;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (stall_q.size() > 0) begin
        mon_s = stall_q.pop_front();
        chk("cpu_stall", 64'(cpu_stall), 64'(mon_s));
      end
      if (cpu_req && !cpu_stall) begin
        if (cpu_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL cpu_grant: got unexpected grant, expected stall (t=%0t)", $time);
        end else begin
          mon_c = cpu_q.pop_front();
          chk("cpu_rd", 64'({cpu_rd1, cpu_rd2}), 64'(mon_c));
        end
      end
      if (dbg_ack) begin
        if (dbg_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL dbg_ack: got unexpected ack, expected none (t=%0t)", $time);
        end else begin
          mon_d = dbg_q.pop_front();
          chk("dbg_rdata", 64'(dbg_rdata), 64'(mon_d));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int lat;
  bit got;

  initial begin
    reset_n = 1'b0; pre = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ra1 = '0; cpu_ra2 = '0; cpu_wd = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wd = '0;
    c_req = 1'b0; c_we = 1'b0; c_ra1 = '0; c_ra2 = '0; c_wd = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0;
    c_pend = 1'b0; d_pend = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 pre = 1'b0;
    @(negedge clk);
    chk("reset_outs", 64'({dbg_ack, init_done, dbg_rdata}), 64'({1'b0, 1'b0, W'(0)}));
    chk("reset_port", 64'({rf_regwrite, rf_ra2}), 64'({1'b1, RB'(1)}));
    @(posedge clk);
    #1 reset_n = 1'b1; cpu_req = 1'b1;
    sweep_check();

    // CPU writes r3, then reads it back
    c_req = 1'b1; c_we = 1'b1; c_ra1 = '0; c_ra2 = RB'(3); c_wd = W'(16'h00A5);
    step(cg, dg);
    c_we = 1'b0; c_ra1 = RB'(3); c_ra2 = '0;
    step(cg, dg);
    // Debug reads r3 and r0 with the CPU idle
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = RB'(3);
    step(cg, dg);
    d_req = 1'b0; step(cg, dg);
    d_req = 1'b1; d_addr = '0;
    step(cg, dg);
    d_req = 1'b0; step(cg, dg);
    // Debug writes r7 (returns old value), CPU reads it back
    d_req = 1'b1; d_we = 1'b1; d_addr = RB'(7); d_wd = W'(16'h1234);
    step(cg, dg);
    d_req = 1'b0; d_we = 1'b0; step(cg, dg);
    c_req = 1'b1; c_ra1 = RB'(7); c_ra2 = RB'(7);
    step(cg, dg);
    // Debug write to r0 is harmless
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = '0; d_wd = W'(16'hFFFF);
    step(cg, dg);
    d_req = 1'b1; d_we = 1'b0; step(cg, dg);
    // Request held through its ack cycle is re-arbitrated the cycle after
    step(cg, dg);
    d_req = 1'b0; step(cg, dg); step(cg, dg);

    // Starvation: CPU holds the port, debug must get through on cycle LIM+1
    d_req = 1'b1; d_we = 1'b0; d_addr = RB'(3); lat = 0; got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      if (!c_pend) begin new_cpu(); c_pend = 1'b1; end
      step(cg, dg);
      if (cg) c_pend = 1'b0;
      if (dg) d_req = 1'b0;
      @(negedge clk);
      if (dbg_ack) begin got = 1'b1; lat = k; end
    end
    chk("starve_latency", 64'(lat), 64'(LIM + 2));
    drain();

    rand_phase(300, 90, 40);
    rand_phase(200, 40, 60);
    drain();

    // Reset during a debug grant aborts it and reruns the sweep
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = RB'(5);
    step(cg, dg);
    #1 reset_n = 1'b0;
    stall_q.delete(); cpu_q.delete(); dbg_q.delete();
    d_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("abort", 64'({dbg_ack, init_done, rf_regwrite, rf_ra2}), 64'({1'b0, 1'b0, 1'b1, RB'(1)}));
    @(posedge clk);
    #1;
    chk("abort_ack", 64'({dbg_ack, init_done}), 64'({1'b0, 1'b0}));
    reset_n = 1'b1; cpu_req = 1'b1;
    sweep_check();

    rand_phase(150, 70, 50);
    drain();
    @(negedge clk);
    chk("queues_empty", 64'(cpu_q.size() + dbg_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
